// File: rtl/sw_logic_serial_if.sv
// Board-side bundle for sw_logic_serial: raw switch/button pins in, LED pins and status out.
// master = pin/board side, slave = logic unit.
interface sw_logic_serial_if;
    logic [31:0] sw_n;
    logic        btn_n;
    logic [31:0] led_n;
    logic        busy;
    logic        done;

    modport master (output sw_n, output btn_n, input led_n, input busy, input done);
    modport slave  (input sw_n, input btn_n, output led_n, output busy, output done);
endinterface

// File: rtl/sw_logic_serial.sv
// Bit-serial bitwise logic unit fed from active-low switches, started by a debounced button press.
// Latency: press event to done = WIDTH+1 cycles (busy for WIDTH); presses while busy or showing are dropped.
// No backpressure; optional SW_LOGIC_POPCNT_EN latches a popcount of the result onto led_n[20:16].
module sw_logic_serial #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    sw_logic_serial_if.slave  io
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        SHOW
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync2_q;
    logic               deb_q, deb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [2:0]         op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               press_evt;
    logic [31:0]        led;
    logic               unused_sw;

    assign unused_sw = ^io.sw_n[31:2*WIDTH+3];

    function automatic logic op_bit(input logic [2:0] op, input logic x, input logic y);
        logic r;
        case (op)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x & y);
            3'b100:  r = ~(x | y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        return r;
    endfunction

    // Level only moves after DEBOUNCE_CYCLES consecutive cycles of disagreement.
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    assign press_evt = deb_q & ~deb_d;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        idx_d    = idx_q;
        work_d   = work_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (press_evt) begin
                    a_d     = ~io.sw_n[WIDTH-1:0];
                    b_d     = ~io.sw_n[2*WIDTH-1:WIDTH];
                    op_d    = ~io.sw_n[2*WIDTH+2:2*WIDTH];
                    work_d  = '0;
                    idx_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d[idx_q] = op_bit(op_q, a_q[idx_q], b_q[idx_q]);
                // idx parks on the last bit rather than wrapping
                if (idx_q == IDX_LAST) begin
                    state_d = SHOW;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            SHOW: begin
                result_d = work_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            deb_q    <= 1'b1;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            work_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            sync1_q  <= io.btn_n;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            idx_q    <= idx_d;
            work_q   <= work_d;
            result_q <= result_d;
        end
    end

`ifdef SW_LOGIC_POPCNT_EN
    logic [4:0] pop_q, pop_d;

    always_comb begin
        pop_d = pop_q;
        if (state_q == SHOW) begin
            pop_d = '0;
            for (int i = 0; i < WIDTH; i++) begin
                pop_d = pop_d + 5'(work_q[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pop_q <= '0;
        end else begin
            pop_q <= pop_d;
        end
    end
`endif

    // LEDs decode from registers only; no path from the switch or button pins.
    always_comb begin
        led             = '1;
        led[WIDTH-1:0]  = ~result_q;
        led[31]         = (state_q != SHIFT);
`ifdef SW_LOGIC_POPCNT_EN
        led[20:16]      = ~pop_q;
`endif
    end

    assign io.led_n = led;
    assign io.busy  = (state_q == SHIFT);
    assign io.done  = (state_q == SHOW);

endmodule

// File: tb/tb_sw_logic_serial.sv
// Directed bench: WIDTH=4/DEBOUNCE=16 main unit plus WIDTH=14 and WIDTH=1 units with short debounce.
module tb_sw_logic_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sw_logic_serial_if io0();
    sw_logic_serial_if io1();
    sw_logic_serial_if io2();

    sw_logic_serial #(.WIDTH(4),  .DEBOUNCE_CYCLES(16)) dut0 (.clk(clk), .rst(rst), .io(io0));
    sw_logic_serial #(.WIDTH(14), .DEBOUNCE_CYCLES(2))  dut1 (.clk(clk), .rst(rst), .io(io1));
    sw_logic_serial #(.WIDTH(1),  .DEBOUNCE_CYCLES(2))  dut2 (.clk(clk), .rst(rst), .io(io2));

    typedef struct {
        logic [31:0] sw;
        logic [31:0] led;
        logic [4:0]  pop;
    } vec_t;

    vec_t vecs[9];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    int   busy_cnt[3];
    int   done_cnt[3];
    int   first_busy[3];
    int   done_cyc[3];
    bit   busy_seen[3];

    task automatic sample(input int k, input logic b, input logic d);
        if (b) begin
            busy_cnt[k]++;
            if (!busy_seen[k]) begin
                busy_seen[k]  = 1'b1;
                first_busy[k] = cyc;
            end
        end
        if (d) begin
            done_cnt[k]++;
            done_cyc[k] = cyc;
        end
    endtask

    always @(negedge clk) begin
        cyc = cyc + 1;
        sample(0, io0.busy, io0.done);
        sample(1, io1.busy, io1.done);
        sample(2, io2.busy, io2.done);
    end

    task automatic clear_mon();
        for (int k = 0; k < 3; k++) begin
            busy_cnt[k]   = 0;
            done_cnt[k]   = 0;
            first_busy[k] = 0;
            done_cyc[k]   = -1000;
            busy_seen[k]  = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_led(input logic [31:0] base, input logic [4:0] pop);
        logic [31:0] r;
        r = base;
`ifdef SW_LOGIC_POPCNT_EN
        r[20:16] = ~pop;
`endif
        return r;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btn(input int k, input logic v);
        case (k)
            0:       io0.btn_n = v;
            1:       io1.btn_n = v;
            default: io2.btn_n = v;
        endcase
    endtask

    task automatic press(input int k, input int low, input int high);
        set_btn(k, 1'b0);
        tick(low);
        set_btn(k, 1'b1);
        tick(high);
    endtask

    // Holds the button until the main unit reports busy; returns whether it did.
    task automatic press_until_busy(output bit found);
        found = 1'b0;
        io0.btn_n = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick(1);
            if (io0.busy) found = 1'b1;
        end
    endtask

    initial begin
        bit found;

        // a=1010 b=0110 across all ops, plus NOT a with a=0011
        vecs[0] = '{32'hFFFF_FF95, 32'hFFFF_FFFD, 5'd1};
        vecs[1] = '{32'hFFFF_FE95, 32'hFFFF_FFF1, 5'd3};
        vecs[2] = '{32'hFFFF_FD95, 32'hFFFF_FFF3, 5'd2};
        vecs[3] = '{32'hFFFF_FC95, 32'hFFFF_FFF2, 5'd3};
        vecs[4] = '{32'hFFFF_FB95, 32'hFFFF_FFFE, 5'd1};
        vecs[5] = '{32'hFFFF_FA95, 32'hFFFF_FFFC, 5'd2};
        vecs[6] = '{32'hFFFF_F995, 32'hFFFF_FFFA, 5'd2};
        vecs[7] = '{32'hFFFF_F895, 32'hFFFF_FFF5, 5'd2};
        vecs[8] = '{32'hFFFF_F9FC, 32'hFFFF_FFF3, 5'd2};

        rst = 1'b1;
        io0.btn_n = 1'b1; io1.btn_n = 1'b1; io2.btn_n = 1'b1;
        io0.sw_n = 32'h0; io1.sw_n = 32'h0; io2.sw_n = 32'h0;
        clear_mon();
        tick(3);
        rst = 1'b0;
        tick(1);
        check("reset_led", io0.led_n, 32'hFFFF_FFFF);
        check("reset_busy", 32'(io0.busy), 32'd0);
        check("reset_done", 32'(io0.done), 32'd0);

        for (int v = 0; v < 9; v++) begin
            clear_mon();
            io0.sw_n = vecs[v].sw;
            press(0, 40, 40);
            check($sformatf("vec%0d_led", v), io0.led_n, exp_led(vecs[v].led, vecs[v].pop));
            check($sformatf("vec%0d_done_cnt", v), 32'(done_cnt[0]), 32'd1);
            check($sformatf("vec%0d_busy_cycles", v), 32'(busy_cnt[0]), 32'd4);
            check($sformatf("vec%0d_busy_to_done", v), 32'(done_cyc[0] - first_busy[0]), 32'd4);
        end

        // short bouncy presses never reach the debounce threshold
        clear_mon();
        for (int r = 0; r < 5; r++) begin
            press(0, 10, 10);
        end
        tick(20);
        check("bounce_done_cnt", 32'(done_cnt[0]), 32'd0);
        check("bounce_busy_cnt", 32'(busy_cnt[0]), 32'd0);
        check("bounce_led_hold", io0.led_n, exp_led(vecs[8].led, vecs[8].pop));

        // reset on the 2nd SHIFT cycle of AND 1111,1111
        clear_mon();
        io0.sw_n = 32'hFFFF_FF00;
        press_until_busy(found);
        check("rstshift_busy_seen", 32'(found), 32'd1);
        io0.btn_n = 1'b1;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(30);
        check("rstshift_done_cnt", 32'(done_cnt[0]), 32'd0);
        check("rstshift_led", io0.led_n, 32'hFFFF_FFFF);
        check("rstshift_busy", 32'(io0.busy), 32'd0);
        clear_mon();
        press(0, 40, 40);
        check("after_rst_led", io0.led_n, exp_led(32'hFFFF_FFF0, 5'd4));
        check("after_rst_done_cnt", 32'(done_cnt[0]), 32'd1);

        // switches flip to all-ones after capture of OR 0001,1000
        clear_mon();
        io0.sw_n = 32'hFFFF_FE7E;
        press_until_busy(found);
        io0.sw_n = 32'hFFFF_FFFF;
        tick(10);
        io0.btn_n = 1'b1;
        tick(40);
        check("swchg_led", io0.led_n, exp_led(32'hFFFF_FFF6, 5'd2));
        check("swchg_done_cnt", 32'(done_cnt[0]), 32'd1);

        // WIDTH=14 XOR 2AAA^0F0F; second press lands mid-SHIFT and is dropped
        clear_mon();
        io1.sw_n = {1'b1, 3'b101, 14'h30F0, 14'h1555};
        press(1, 4, 4);
        press(1, 4, 40);
        check("w14_done_cnt", 32'(done_cnt[1]), 32'd1);
        check("w14_busy_cycles", 32'(busy_cnt[1]), 32'd14);
        check("w14_led", io1.led_n, exp_led(32'hFFFF_DA5A, 5'd7));

        // WIDTH=1 OR a=0 b=1
        clear_mon();
        io2.sw_n = 32'hFFFF_FFF9;
        press(2, 4, 30);
        check("w1_done_cnt", 32'(done_cnt[2]), 32'd1);
        check("w1_busy_cycles", 32'(busy_cnt[2]), 32'd1);
        check("w1_busy_to_done", 32'(done_cyc[2] - first_busy[2]), 32'd1);
        check("w1_led", io2.led_n, exp_led(32'hFFFF_FFFE, 5'd1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sw_logic_serial.md
Name: sw_logic_serial

Overview:
- Parametrised, bit-serial bitwise logic unit driven from active-low board switches and a push button; results are shown on active-low LEDs.
- Operands and an operation code are read from switch fields and captured on a debounced button press.
- The result is computed one bit per clock, then latched onto the LEDs with a done pulse.
- Sits directly between the board switch/button pins and the LED pins of the lab top level.

Parameters:
WIDTH, 4, operand/result width in bits; legal range 1..14 (2*WIDTH+3 <= 31)
DEBOUNCE_CYCLES, 16, consecutive stable cycles needed for a button level change; legal range >= 2
CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width; derived, not overridden

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
sw_n  input  32  active-low switches: a=~sw_n[WIDTH-1:0], b=~sw_n[2*WIDTH-1:WIDTH], op=~sw_n[2*WIDTH+2:2*WIDTH], rest ignored
btn_n  input  1  active-low go button, asynchronous/bouncy
led_n  output  32  active-low LEDs: led_n[WIDTH-1:0]=~result, led_n[31]=~busy, all other bits 1 (off)
busy  output  1  high while serial computation runs
done  output  1  one-cycle pulse when a new result is latched

Behaviour:
- Reset, synchronous active-high, single clock: state=IDLE; busy=0; done=0; result=0; led_n=32'hFFFF_FFFF; sync flops=1 (released); debounced level=released; debounce count=0; operand/op registers=0.
- Button path: 2-flop synchronizer on btn_n, then debounce counter.
  - Counter increments while synced value != debounced level; clears to 0 when they are equal.
  - When counter == DEBOUNCE_CYCLES-1 and values still differ, debounced level takes the synced value and counter clears.
  - press_evt = debounced level changing released->pressed; exactly one event per press, however long held.
- Op codes (op after inversion): 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a (b ignored), 111 pass a.
- FSM states: IDLE, SHIFT, SHOW.
  - IDLE: on press_evt, capture a, b, op from sw_n into registers; clear working result; idx=0; go to SHIFT.
  - SHIFT: busy=1. Each cycle write work[idx]=f(a[idx],b[idx]); idx increments. After the bit WIDTH-1 write, go to SHOW.
  - SHOW: result<=work; done=1 for this cycle only; busy=0; return to IDLE.
- Latency: press_evt edge to done = WIDTH+1 cycles; busy high for exactly WIDTH cycles.
- Boundary conditions:
  - Switch changes after capture have no effect on the result in progress.
  - press_evt in SHIFT or SHOW is dropped, not queued.
  - Reset mid-SHIFT aborts the operation and clears result and LEDs; no done pulse.
  - result and led_n hold their last value between operations.
  - WIDTH=1 gives busy for 1 cycle.
  - idx width is $clog2(WIDTH) with minimum 1 and must not wrap before the SHOW transition.
- led_n is fully registered, or combinational from registers only, with no path from sw_n or btn_n.

Optional Feature:
- Macro: SW_LOGIC_POPCNT_EN.
- Defined: in SHOW, a 5-bit count of ones in result is latched. led_n[20:16]=~popcount and led_n[23:21]=1. The count resets to 0 (led_n[20:16]=5'b11111).
- Undefined: no popcount logic; led_n[23:16] stay 1.

Test Plan:
- Reset for 3 cycles with btn_n=1, sw_n=32'h0 -> led_n=32'hFFFF_FFFF, busy=0, done=0.
- WIDTH=4, DEBOUNCE_CYCLES=16, sw_n=32'hFFFF_FD95 (a=1010, b=0110, op XOR), hold btn_n=0 for 40 cycles -> single press_evt; busy=1 for 4 cycles; done pulse one cycle; led_n=32'hFFFF_FFF3. With SW_LOGIC_POPCNT_EN: led_n=32'hFFFD_FFF3.
- btn_n toggled low for 10 cycles then high, repeated 5 times -> no press_evt, busy never asserts, led_n unchanged.
- Start op 110 (NOT a, a=0011, sw_n=32'hFFFF_F9FC) -> result 1100. A second clean press during busy is ignored: exactly one done pulse; led_n[3:0]=4'b0011.
- Start AND with a=1111, b=1111, then assert rst on the 2nd SHIFT cycle -> no done pulse; led_n=32'hFFFF_FFFF; the next press after release computes normally (led_n[3:0]=4'b0000).
- Change sw_n to all ones during SHIFT after capture of OR a=0001, b=1000 -> led_n[3:0]=4'b0110 (result 1001, captured operands used).
